// File: rtl/latch_write_arbiter_pkg.sv
// Shared definitions for the latch write arbiter.
//   - Default bus widths used by the interface and the top module.
//   - Write-sequence state encoding: IDLE, then SETUP, ENABLE and HOLD, one cycle each.
package latch_write_arbiter_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } wr_state_e;

endpackage

// File: rtl/latch_write_arbiter_if.sv
// Bus between two write requesters and the latch write arbiter.
//   req0/req1     : level write requests, held until the matching ack
//   addr0/addr1   : target latch word of each requester
//   data0/data1   : write data of each requester
//   ack0/ack1     : one-cycle acceptance pulse
//   latch_d       : shared data bus to the latch bank D inputs
//   latch_en      : one-hot enable bus, one bit per latch word
//   busy          : write sequence in progress
// The master modport is the requester/latch-bank side; the slave modport is the arbiter.
interface latch_write_arbiter_if
  import latch_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) ();

  localparam int N_WORDS = 1 << ADDR_W;

  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] latch_d;
  logic [N_WORDS-1:0] latch_en;
  logic              busy;

  modport master (
    output req0, req1, addr0, addr1, data0, data1,
    input  ack0, ack1, latch_d, latch_en, busy
  );

  modport slave (
    input  req0, req1, addr0, addr1, data0, data1,
    output ack0, ack1, latch_d, latch_en, busy
  );

endinterface

// File: rtl/latch_write_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter.
//   clk, reset : clock and synchronous active-high reset
//   req[1:0]   : request vector
//   en         : arbitration allowed this cycle
//   grant[1:0] : one-hot grant (all zero when en is low or no request)
// A lone request always wins. With both requests pending the pointer holder
// wins. After every grant the pointer moves to the requester that did not win.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant = 2'b00;
    ptr_d = ptr_q;
    if (en) begin
      if (req == 2'b11) begin
        grant = ptr_q ? 2'b10 : 2'b01;
      end else begin
        grant = req;
      end
      // Winner 0 hands priority to 1 and the reverse.
      if (grant != 2'b00) begin
        ptr_d = grant[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// Arbitrates writes from two requesters into an external latch bank.
//   clk, reset : clock and synchronous active-high reset
//   bus        : requester handshake plus latch_d / latch_en / busy
// A granted write runs SETUP (data driven, ack pulse), ENABLE (one-hot enable),
// HOLD (data held, enable low), then returns to IDLE. Every output comes
// straight from a flop, so no input reaches latch_en combinationally.
module latch_write_arbiter
  import latch_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  latch_write_arbiter_if.slave  bus
);

  localparam int N_WORDS = 1 << ADDR_W;

  wr_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic [DATA_W-1:0]  latch_d_q, latch_d_d;
  logic [N_WORDS-1:0] latch_en_q, latch_en_d;
  logic               busy_q, busy_d;

  logic [1:0]         grant;
  logic [N_WORDS-1:0] addr_onehot;

  rr_arbiter_2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({bus.req1, bus.req0}),
    .en    (state_q == IDLE),
    .grant (grant)
  );

  // One-hot decode of the captured address.
  for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_decode
    assign addr_onehot[gi] = (addr_q == ADDR_W'(gi));
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    latch_d_d  = latch_d_q;
    latch_en_d = '0;

    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          state_d = SETUP;
          if (grant[1]) begin
            addr_d = bus.addr1;
            data_d = bus.data1;
          end else begin
            addr_d = bus.addr0;
            data_d = bus.data0;
          end
          // Registered so ack and the data bus appear together in SETUP.
          ack0_d    = grant[0];
          ack1_d    = grant[1];
          latch_d_d = data_d;
        end
      end
      SETUP: begin
        state_d    = ENABLE;
        latch_en_d = addr_onehot;
      end
      ENABLE: begin
        state_d = HOLD;
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      latch_d_q  <= '0;
      latch_en_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      latch_d_q  <= latch_d_d;
      latch_en_q <= latch_en_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.latch_d  = latch_d_q;
  assign bus.latch_en = latch_en_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Self-checking bench for latch_write_arbiter: directed scenarios plus a
// randomized run, all outputs compared every cycle against a write-schedule
// reference model.
module tb_latch_write_arbiter;
  import latch_write_arbiter_pkg::*;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 2;
  localparam int N_WORDS = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  latch_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  latch_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_on = 1'b0;

  // Reference model: a granted write occupies the next three cycles
  // (remaining = 3, 2, 1 -> setup, enable, hold).
  int                 m_rem = 0;
  int                 m_ptr = 0;
  int                 m_win = 0;
  logic [ADDR_W-1:0]  m_addr = '0;
  logic [DATA_W-1:0]  m_data = '0;
  logic               e_ack0 = 1'b0, e_ack1 = 1'b0, e_busy = 1'b0;
  logic [N_WORDS-1:0] e_en = '0;
  logic [DATA_W-1:0]  e_d = '0;

  typedef struct { int who; int cyc; } ack_t;
  ack_t ack_log[$];

  task automatic model_step();
    if (reset) begin
      m_rem = 0; m_ptr = 0; m_win = 0; m_addr = '0; m_data = '0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
    end else if (bus.req0 || bus.req1) begin
      if (bus.req0 && bus.req1) m_win = m_ptr;
      else m_win = bus.req1 ? 1 : 0;
      m_ptr  = 1 - m_win;
      m_addr = (m_win == 1) ? bus.addr1 : bus.addr0;
      m_data = (m_win == 1) ? bus.data1 : bus.data0;
      m_rem  = 3;
    end
    e_busy = (m_rem > 0);
    e_ack0 = (m_rem == 3) && (m_win == 0);
    e_ack1 = (m_rem == 3) && (m_win == 1);
    e_en   = '0;
    if (m_rem == 2) e_en[m_addr] = 1'b1;
    e_d    = m_data;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    cyc++;
  end

  // Per-cycle monitor at the falling edge.
  logic [N_WORDS-1:0] prev_en = '0;
  logic               prev_ack = 1'b0;
  logic               prev_busy = 1'b0;
  logic [DATA_W-1:0]  prev_d = '0;

  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      checks++;
      if (bus.ack0 !== e_ack0 || bus.ack1 !== e_ack1) begin
        errors++;
        $display("FAIL mon_ack cyc=%0d got=%b%b exp=%b%b", cyc, bus.ack1, bus.ack0, e_ack1, e_ack0);
      end
      checks++;
      if (bus.latch_en !== e_en) begin
        errors++;
        $display("FAIL mon_latch_en cyc=%0d got=%b exp=%b", cyc, bus.latch_en, e_en);
      end
      checks++;
      if (bus.latch_d !== e_d) begin
        errors++;
        $display("FAIL mon_latch_d cyc=%0d got=%h exp=%h", cyc, bus.latch_d, e_d);
      end
      checks++;
      if (bus.busy !== e_busy) begin
        errors++;
        $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, e_busy);
      end
      checks++;
      if ($countones(bus.latch_en) > 1 || (prev_en != '0 && bus.latch_en != '0)) begin
        errors++;
        $display("FAIL mon_en_shape cyc=%0d got=%b prev=%b exp=onehot0,non-consecutive", cyc, bus.latch_en, prev_en);
      end
      checks++;
      if ((bus.ack0 && bus.ack1) || (prev_ack && (bus.ack0 || bus.ack1))) begin
        errors++;
        $display("FAIL mon_ack_shape cyc=%0d got=%b%b prev=%b exp=single isolated pulse", cyc, bus.ack1, bus.ack0, prev_ack);
      end
      checks++;
      if (prev_busy && bus.busy && bus.latch_d !== prev_d) begin
        errors++;
        $display("FAIL mon_d_stable cyc=%0d got=%h exp=%h", cyc, bus.latch_d, prev_d);
      end
      if (bus.ack0 || bus.ack1) begin
        ack_log.push_back('{who: (bus.ack1 ? 1 : 0), cyc: cyc});
        $display("write req%0d cyc=%0d data=%h", bus.ack1 ? 1 : 0, cyc, bus.latch_d);
      end
    end
    prev_en   = bus.latch_en;
    prev_ack  = bus.ack0 || bus.ack1;
    prev_busy = bus.busy;
    prev_d    = bus.latch_d;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drop_all();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  task automatic test_reset();
    drop_all();
    bus.addr0 = '0; bus.addr1 = '0; bus.data0 = '0; bus.data1 = '0;
    reset = 1'b1;
    tick(2);
    mon_on = 1'b1;
    checks++;
    if ({bus.ack0, bus.ack1, bus.busy, bus.latch_en, bus.latch_d} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b%b %b %h exp=all zero", bus.ack0, bus.ack1, bus.busy, bus.latch_en, bus.latch_d);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    bus.req0 = 1'b1; bus.addr0 = 2'd2; bus.data0 = 8'hA5;
    tick();
    checks++;
    if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0 || bus.latch_en !== 4'b0000 || bus.latch_d !== 8'hA5) begin
      errors++;
      $display("FAIL single_setup got=ack%b%b en=%b d=%h exp=ack01 en=0000 d=a5", bus.ack1, bus.ack0, bus.latch_en, bus.latch_d);
    end
    bus.req0 = 1'b0;
    tick();
    checks++;
    if (bus.latch_en !== 4'b0100 || bus.latch_d !== 8'hA5 || bus.ack0 !== 1'b0) begin
      errors++;
      $display("FAIL single_enable got=en=%b d=%h ack0=%b exp=en=0100 d=a5 ack0=0", bus.latch_en, bus.latch_d, bus.ack0);
    end
    tick();
    checks++;
    if (bus.latch_en !== 4'b0000 || bus.latch_d !== 8'hA5 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_hold got=en=%b d=%h busy=%b exp=en=0000 d=a5 busy=1", bus.latch_en, bus.latch_d, bus.busy);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.latch_d !== 8'hA5) begin
      errors++;
      $display("FAIL single_idle got=busy=%b d=%h exp=busy=0 d=a5", bus.busy, bus.latch_d);
    end
  endtask

  task automatic test_contention();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ack_log.delete();
    bus.req0 = 1'b1; bus.addr0 = 2'd1; bus.data0 = 8'h11;
    bus.req1 = 1'b1; bus.addr1 = 2'd3; bus.data1 = 8'h22;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ack0) bus.req0 = 1'b0;
      if (bus.ack1) bus.req1 = 1'b0;
    end
    checks++;
    if (ack_log.size() != 2 || ack_log[0].who != 0 || ack_log[1].who != 1) begin
      errors++;
      $display("FAIL contention_order got=%0d acks first=%0d exp=2 acks order 0,1", ack_log.size(),
               (ack_log.size() > 0) ? ack_log[0].who : -1);
    end
  endtask

  task automatic test_fairness();
    int start;
    bit alt_ok;
    ack_log.delete();
    start = m_ptr;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 60 && ack_log.size() < 8; i++) begin
      tick();
      if (bus.ack0) bus.data0 = 8'($urandom);
      if (bus.ack1) bus.data1 = 8'($urandom);
    end
    drop_all();
    checks++;
    if (ack_log.size() != 8) begin
      errors++;
      $display("FAIL fairness_count got=%0d exp=8", ack_log.size());
    end
    alt_ok = 1'b1;
    for (int i = 0; i < ack_log.size(); i++) begin
      if (ack_log[i].who != (start + i) % 2) alt_ok = 1'b0;
      if (i > 0 && ack_log[i].cyc - ack_log[i-1].cyc != 4) alt_ok = 1'b0;
    end
    checks++;
    if (!alt_ok) begin
      errors++;
      $display("FAIL fairness_alternate got=non-alternating or spacing!=4 exp=alternate from %0d every 4 cycles", start);
    end
    tick(4);
  endtask

  task automatic test_reset_in_enable();
    bit found;
    bus.req0 = 1'b1; bus.addr0 = 2'd0; bus.data0 = 8'h3C;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus.ack0) bus.req0 = 1'b0;
      if (bus.latch_en == 4'b0001) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_en_reach got=no enable exp=latch_en 0001 within 10 cycles");
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.ack0, bus.ack1, bus.busy, bus.latch_en, bus.latch_d} !== '0) begin
      errors++;
      $display("FAIL rst_en_outputs got=%b%b%b %b %h exp=all zero", bus.ack0, bus.ack1, bus.busy, bus.latch_en, bus.latch_d);
    end
    reset = 1'b0;
    ack_log.delete();
    bus.req0 = 1'b1; bus.data0 = 8'h44;
    bus.req1 = 1'b1; bus.data1 = 8'h55;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.ack0) bus.req0 = 1'b0;
      if (bus.ack1) bus.req1 = 1'b0;
    end
    checks++;
    if (ack_log.size() < 1 || ack_log[0].who != 0) begin
      errors++;
      $display("FAIL rst_en_pointer got=%0d exp=requester 0 first", (ack_log.size() > 0) ? ack_log[0].who : -1);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.ack0) bus.req0 = 1'b0;
      if (bus.ack1) bus.req1 = 1'b0;
    end
    drop_all();
    tick(4);
  endtask

  task automatic test_late_request();
    int t0, t1;
    t0 = -1; t1 = -1;
    bus.req0 = 1'b1; bus.addr0 = 2'd1; bus.data0 = 8'h5A;
    for (int i = 0; i < 10 && t0 < 0; i++) begin
      tick();
      if (bus.ack0) t0 = cyc;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.addr1 = 2'd3; bus.data1 = 8'hC3;
    if (bus.ack1) t1 = cyc;
    for (int i = 0; i < 10 && t1 < 0; i++) begin
      tick();
      if (bus.ack1) t1 = cyc;
    end
    bus.req1 = 1'b0;
    checks++;
    if (t0 < 0 || t1 - t0 != 4) begin
      errors++;
      $display("FAIL late_request got=ack0@%0d ack1@%0d exp=ack1 4 cycles after ack0", t0, t1);
    end
    tick(4);
  endtask

  task automatic test_random();
    int n0;
    n0 = ack_log.size();
    for (int i = 0; i < 600; i++) begin
      if (bus.ack0) bus.req0 = 1'b0;
      else if (!bus.req0 && $urandom_range(0, 2) == 0) begin
        bus.req0 = 1'b1; bus.addr0 = ADDR_W'($urandom); bus.data0 = DATA_W'($urandom);
      end
      if (bus.ack1) bus.req1 = 1'b0;
      else if (!bus.req1 && $urandom_range(0, 2) == 0) begin
        bus.req1 = 1'b1; bus.addr1 = ADDR_W'($urandom); bus.data1 = DATA_W'($urandom);
      end
      reset = ($urandom_range(0, 79) == 0);
      tick();
    end
    reset = 1'b0;
    drop_all();
    tick(5);
    checks++;
    if (ack_log.size() - n0 < 50) begin
      errors++;
      $display("FAIL random_activity got=%0d writes exp=at least 50", ack_log.size() - n0);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_fairness();
    test_reset_in_enable();
    test_late_request();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
